// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: ALU ops, opcodes, functs,
// FSM state codes, mux selects and the registered control-word layout.
package mips_ctrl_pkg;

  localparam logic [2:0] A_NOP = 3'd0;
  localparam logic [2:0] A_ADD = 3'd1;
  localparam logic [2:0] A_SUB = 3'd2;
  localparam logic [2:0] A_AND = 3'd3;
  localparam logic [2:0] A_OR  = 3'd4;
  localparam logic [2:0] A_XOR = 3'd5;
  localparam logic [2:0] A_NOR = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [3:0] S_RESET  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_RTEX   = 4'd3;
  localparam logic [3:0] S_RTWB   = 4'd4;
  localparam logic [3:0] S_MEMADR = 4'd5;
  localparam logic [3:0] S_MEMRD  = 4'd6;
  localparam logic [3:0] S_MEMWB  = 4'd7;
  localparam logic [3:0] S_MEMWR  = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JMP    = 4'd12;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // fetch marks the FETCH cycle; ir_write and the fetch PC update are gated by mem_ready.
  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic ctrl_t ctrl_for_state(input logic [3:0] st,
                                           input logic [2:0] rt_op,
                                           input logic       rt_illegal,
                                           input logic       from_decode);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = A_ADD;
        c.pc_src    = PCSRC_ALU;
        // Arriving straight from DECODE means the opcode was not recognised.
        c.illegal   = from_decode;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = A_ADD;
      end
      S_RTEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = rt_op;
        c.illegal   = rt_illegal;
      end
      S_RTWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = A_ADD;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = A_SUB;
        c.pc_src        = PCSRC_ALUOUT;
        c.pc_write_cond = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      S_JMP: begin
        c.pc_src   = PCSRC_JUMP;
        c.pc_write = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in, mux/enable controls out.
interface mips_mc_control_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       illegal;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal
  );

endinterface

// File: rtl/mips_mc_control_funct_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags unsupported functs.
import mips_ctrl_pkg::*;

module mips_funct_dec (
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = A_NOP;
    illegal = 1'b0;
    case (funct)
      FN_ADD, FN_ADDU: alu_op = A_ADD;
      FN_SUB, FN_SUBU: alu_op = A_SUB;
      FN_AND:          alu_op = A_AND;
      FN_OR:           alu_op = A_OR;
      FN_XOR:          alu_op = A_XOR;
      FN_NOR:          alu_op = A_NOR;
      default:         illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main controller: Moore FSM whose outputs are registered from next_state,
// so each state's controls are valid during that state's own cycle.
import mips_ctrl_pkg::*;

module mips_mc_control #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_mc_control_if.master  bus
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic [5:0] dec_funct;
  logic [2:0] dec_op;
  logic       dec_illegal;
  logic       mem_rdy;
  logic       pc_write_all;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;

  assign mem_rdy = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  // RTEX controls are registered on the DECODE->RTEX edge, before funct_q is loaded.
  assign dec_funct = (state == S_DECODE) ? bus.funct : funct_q;

  mips_funct_dec u_funct_dec (
    .funct   (dec_funct),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH:  next_state = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     next_state = S_RTEX;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BEQ;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_RTEX:   next_state = dec_illegal ? S_FETCH : S_RTWB;
      S_MEMADR: next_state = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_rdy ? S_FETCH : S_MEMWR;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  assign ctrl_d = ctrl_for_state(next_state, dec_op, dec_illegal, state == S_DECODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RESET;
      ctrl_q <= CTRL_IDLE;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_d;
    end
  end

  // Instruction fields are only meaningful once DECODE has captured them.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) begin
      opcode_q <= bus.opcode;
      funct_q  <= bus.funct;
    end
  end

  assign pc_write_all      = ctrl_q.pc_write | (ctrl_q.fetch & mem_rdy);
  assign bus.pc_write      = pc_write_all;
  assign bus.ir_write      = ctrl_q.fetch & mem_rdy;
  assign bus.pc_en         = pc_write_all | (ctrl_q.pc_write_cond & bus.alu_zero);
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.iord          = ctrl_q.iord;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.pc_src        = ctrl_q.pc_src;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.illegal       = ctrl_q.illegal;

endmodule
